// File: rtl/shift_pkg.sv
// Shared encodings for the mode-controlled shift register and its command sequencer.
// The op codes double as the register's M input, so a captured op can drive M directly.
package shift_pkg;

    localparam logic [1:0] OP_HOLD     = 2'b00;
    localparam logic [1:0] OP_LOAD     = 2'b01;
    localparam logic [1:0] OP_ROTATE   = 2'b10;
    localparam logic [1:0] OP_SHIFT_IN = 2'b11;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

endpackage

// File: rtl/seq_cnt.sv
// Loadable down counter with a zero flag; it saturates at zero instead of wrapping.
module seq_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/shift_seq.sv
// Command sequencer for the 4-bit mode-controlled shift register: one command per handshake,
// driving M, D and SI for the requested number of cycles, then a single-cycle done pulse.
module shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [1:0]       M,
    output logic [WIDTH-1:0] D,
    output logic             SI,
    output logic             busy,
    output logic             done
);

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] bitIdx_q, bitIdx_d;
    logic [1:0]       M_q, M_d;
    logic [WIDTH-1:0] D_q, D_d;
    logic             SI_q, SI_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] effCount;
    logic             cntLoad;
    logic [CNT_W-1:0] cntLoadVal;
    logic             cntDec;
    logic             cntZero;
    logic             nextSerialBit;

    seq_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .load_i (cntLoad),
        .value_i(cntLoadVal),
        .dec_i  (cntDec),
        .zero_o (cntZero)
    );

    assign effCount      = (cmd_op == OP_LOAD) ? CNT_W'(1) : cmd_count;
    // Bits beyond the data word are sent as zeros, so the masked lookup is gated by the index range.
    assign nextSerialBit = (int'(bitIdx_q) < WIDTH) && (|(data_q & (WIDTH'(1) << bitIdx_q)));

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        bitIdx_d   = bitIdx_q;
        M_d        = OP_HOLD;
        D_d        = D_q;
        SI_d       = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        cntLoad    = 1'b0;
        cntLoadVal = effCount - CNT_W'(1);
        cntDec     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    busy_d = 1'b1;
                    if (effCount == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // The first operation cycle is presented straight from the accepting edge.
                        state_d  = S_RUN;
                        M_d      = cmd_op;
                        cntLoad  = 1'b1;
                        bitIdx_d = CNT_W'(1);
                        if (cmd_op == OP_LOAD) begin
                            D_d = cmd_data;
                        end
                        if (cmd_op == OP_SHIFT_IN) begin
                            SI_d = cmd_data[0];
                        end
                    end
                end
            end
            S_RUN: begin
                busy_d = 1'b1;
                if (cntZero) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    cntDec   = 1'b1;
                    M_d      = op_q;
                    bitIdx_d = bitIdx_q + CNT_W'(1);
                    if (op_q == OP_SHIFT_IN) begin
                        SI_d = nextSerialBit;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_HOLD;
            data_q   <= '0;
            bitIdx_q <= '0;
            M_q      <= OP_HOLD;
            D_q      <= '0;
            SI_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            data_q   <= data_d;
            bitIdx_q <= bitIdx_d;
            M_q      <= M_d;
            D_q      <= D_d;
            SI_q     <= SI_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign M         = M_q;
    assign D         = D_q;
    assign SI        = SI_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench: shift_seq drives a behavioural 4-bit mode-controlled shift register,
// and both the sequencer outputs and the register contents are compared to hand-computed values.
module tb_shift_seq;
    import shift_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_count;
    logic [3:0] cmd_data;
    logic [1:0] M;
    logic [3:0] D;
    logic       SI;
    logic       busy;
    logic       done;
    logic [3:0] q;

    int testsRun = 0;
    int testsFailed = 0;

    logic [1:0] mTrace    [48];
    logic       siTrace   [48];
    logic [3:0] qTrace    [48];
    logic [3:0] dTrace    [48];
    logic       doneTrace [48];
    int         lastK;
    int         doneSeen;
    int         opSeen;
    int         gap;
    int         early;

    shift_seq #(
        .WIDTH(4),
        .CNT_W(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_count(cmd_count),
        .cmd_data (cmd_data),
        .M        (M),
        .D        (D),
        .SI       (SI),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Downstream register: rotate left, shift-in enters at the MSB and moves right.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 4'h0;
        end else begin
            case (M)
                OP_LOAD:     q <= D;
                OP_ROTATE:   q <= {q[2:0], q[3]};
                OP_SHIFT_IN: q <= {SI, q[3:1]};
                default:     q <= q;
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] count, input logic [3:0] data);
        int guard = 0;
        cmd_op    = op;
        cmd_count = count;
        cmd_data  = data;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("readyBeforeAccept", 16'(cmd_ready), 16'h1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_count = 4'hF;
        cmd_data  = ~data;
    endtask

    // Cycle k is the low phase k clocks after the accepting edge.
    task automatic watchCommand(input logic [1:0] op);
        doneSeen = 0;
        opSeen   = 0;
        lastK    = 0;
        for (int k = 1; k < 48; k++) begin
            @(negedge clk);
            mTrace[k]    = M;
            siTrace[k]   = SI;
            qTrace[k]    = q;
            dTrace[k]    = D;
            doneTrace[k] = done;
            if (done === 1'b1) doneSeen++;
            if (M === op && op != OP_HOLD) opSeen++;
            lastK = k;
            if (busy !== 1'b1) break;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run did not complete, observed timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_HOLD;
        cmd_count = 4'h0;
        cmd_data  = 4'h0;
        #3 reset = 1'b0;
        #9;
        checkOutput("rstM", 16'(M), 16'h0);
        checkOutput("rstD", 16'(D), 16'h0);
        checkOutput("rstSI", 16'(SI), 16'h0);
        checkOutput("rstBusy", 16'(busy), 16'h0);
        checkOutput("rstDone", 16'(done), 16'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstReady", 16'(cmd_ready), 16'h1);

        // LOAD ignores its count field.
        applyStimulus(OP_LOAD, 4'd5, 4'b1011);
        watchCommand(OP_LOAD);
        checkOutput("loadM", 16'(mTrace[1]), 16'h1);
        checkOutput("loadD", 16'(dTrace[1]), 16'hB);
        checkOutput("loadNoEarlyDone", 16'(doneTrace[1]), 16'h0);
        checkOutput("loadDone", 16'(doneTrace[2]), 16'h1);
        checkOutput("loadDoneM", 16'(mTrace[2]), 16'h0);
        checkOutput("loadDoneCount", 16'(doneSeen), 16'd1);
        checkOutput("loadLen", 16'(lastK), 16'd3);
        checkOutput("loadQ", 16'(qTrace[3]), 16'hB);

        applyStimulus(OP_ROTATE, 4'd3, 4'b1111);
        watchCommand(OP_ROTATE);
        checkOutput("rotCycles", 16'(opSeen), 16'd3);
        checkOutput("rotQ1", 16'(qTrace[2]), 16'h7);
        checkOutput("rotQ2", 16'(qTrace[3]), 16'hE);
        checkOutput("rotQ3", 16'(qTrace[4]), 16'hD);
        checkOutput("rotDone", 16'(doneTrace[4]), 16'h1);
        checkOutput("rotDoneCount", 16'(doneSeen), 16'd1);
        checkOutput("rotDKept", 16'(dTrace[2]), 16'hB);
        checkOutput("rotLen", 16'(lastK), 16'd5);

        applyStimulus(OP_LOAD, 4'd0, 4'b0000);
        watchCommand(OP_LOAD);
        checkOutput("clearQ", 16'(qTrace[3]), 16'h0);

        applyStimulus(OP_SHIFT_IN, 4'd4, 4'b0110);
        watchCommand(OP_SHIFT_IN);
        checkOutput("sh4M", 16'(mTrace[1]), 16'h3);
        checkOutput("sh4Cycles", 16'(opSeen), 16'd4);
        checkOutput("sh4Bits", 16'({siTrace[4], siTrace[3], siTrace[2], siTrace[1]}), 16'h6);
        checkOutput("sh4Done", 16'(doneTrace[5]), 16'h1);
        checkOutput("sh4Q", 16'(qTrace[6]), 16'h6);
        checkOutput("sh4Len", 16'(lastK), 16'd6);

        applyStimulus(OP_SHIFT_IN, 4'd6, 4'b0110);
        watchCommand(OP_SHIFT_IN);
        checkOutput("sh6Cycles", 16'(opSeen), 16'd6);
        checkOutput("sh6Bits", 16'({siTrace[6], siTrace[5], siTrace[4], siTrace[3], siTrace[2], siTrace[1]}), 16'h06);
        checkOutput("sh6Q", 16'(qTrace[8]), 16'h1);
        checkOutput("sh6Len", 16'(lastK), 16'd8);

        applyStimulus(OP_ROTATE, 4'd0, 4'b1010);
        watchCommand(OP_ROTATE);
        checkOutput("rot0Cycles", 16'(opSeen), 16'd0);
        checkOutput("rot0Done", 16'(doneTrace[1]), 16'h1);
        checkOutput("rot0M", 16'(mTrace[1]), 16'h0);
        checkOutput("rot0Len", 16'(lastK), 16'd2);
        checkOutput("rot0Q", 16'(qTrace[2]), 16'h1);

        // A second command is held on cmd_valid throughout a 2-cycle HOLD.
        checkOutput("heldReady0", 16'(cmd_ready), 16'h1);
        cmd_op    = OP_HOLD;
        cmd_count = 4'd2;
        cmd_data  = 4'h0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_op    = OP_ROTATE;
        cmd_count = 4'd1;
        gap       = 0;
        early     = 0;
        for (int g = 0; g < 20; g++) begin
            @(negedge clk);
            gap++;
            if (M === OP_ROTATE) early++;
            if (cmd_ready === 1'b1) break;
        end
        checkOutput("heldGap", 16'(gap), 16'd4);
        checkOutput("heldEarly", 16'(early), 16'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        watchCommand(OP_ROTATE);
        checkOutput("heldRotCycles", 16'(opSeen), 16'd1);
        checkOutput("heldRotQ", 16'(qTrace[2]), 16'h2);
        checkOutput("heldRotLen", 16'(lastK), 16'd3);

        applyStimulus(OP_SHIFT_IN, 4'd4, 4'b1111);
        @(negedge clk);
        checkOutput("abortSi1", 16'(SI), 16'h1);
        @(negedge clk);
        checkOutput("abortSi2", 16'(SI), 16'h1);
        #2 reset = 1'b0;
        #1;
        checkOutput("abortM", 16'(M), 16'h0);
        checkOutput("abortSI", 16'(SI), 16'h0);
        checkOutput("abortBusy", 16'(busy), 16'h0);
        checkOutput("abortDone", 16'(done), 16'h0);
        checkOutput("abortD", 16'(D), 16'h0);
        @(negedge clk);
        reset    = 1'b1;
        doneSeen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) doneSeen++;
        end
        checkOutput("abortNoDone", 16'(doneSeen), 16'd0);
        checkOutput("abortReady", 16'(cmd_ready), 16'h1);

        applyStimulus(OP_LOAD, 4'd0, 4'b1001);
        watchCommand(OP_LOAD);
        checkOutput("postAbortQ", 16'(qTrace[3]), 16'h9);
        checkOutput("postAbortDone", 16'(doneSeen), 16'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
